// File: rtl/pe_types_pkg.sv
// Shared PE cluster types: boundary packet payload and port buffer defaults.
package pe_types;

    localparam int unsigned PKT_DATA_W     = 8;
    // Default entries per boundary port buffer channel
    localparam int unsigned PORT_BUF_DEPTH = 2;

    typedef struct packed {
        logic [PKT_DATA_W-1:0] data;
    } packet_t;

endpackage

// File: rtl/pe_port_fifo.sv
// Single-channel boundary FIFO with registered count/pointers.
//   up_empty/up_rdata/up_deq : upstream pop interface (up_deq combinational)
//   dn_deq/dn_empty/dn_rdata : downstream pop interface (head read from regs)
//   flush                    : synchronous discard of all entries
//   nonempty                 : count != 0, for the cluster busy flag
module pe_port_fifo
    import pe_types::*;
#(
    parameter int unsigned DEPTH = PORT_BUF_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    up_empty,
    input  packet_t up_rdata,
    output logic    up_deq,
    input  logic    dn_deq,
    output logic    dn_empty,
    output packet_t dn_rdata,
    output logic    nonempty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    packet_t          mem [DEPTH];
    logic             pop;

    // Full blocks the pop even when downstream frees a slot this cycle
    assign up_deq   = rst && !up_empty && (count < CNT_W'(DEPTH)) && !flush;
    assign pop      = dn_deq && (count != '0) && !flush;
    assign dn_empty = (count == '0);
    assign nonempty = (count != '0);
    assign dn_rdata = mem[rd_ptr];

    // Control state; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (up_deq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({up_deq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage, not reset
    always_ff @(posedge clk) begin
        if (up_deq) mem[wr_ptr] <= up_rdata;
    end

endmodule

// File: rtl/pe_cluster_port_buf.sv
// Per-channel boundary buffer between pe_cluster ingress/egress arrays.
//   up_empty/up_rdata/up_deq : upstream deq/empty/rdata per channel
//   dn_deq/dn_empty/dn_rdata : downstream deq/empty/rdata per channel
//   flush                    : synchronous discard of all buffered entries
//   busy                     : any active channel holds an entry
// Channels with ACTIVE_MASK bit 0 are tied off and carry no storage.
module pe_cluster_port_buf
    import pe_types::*;
#(
    parameter int unsigned          CHANNELS    = 8,
    parameter int unsigned          DEPTH       = PORT_BUF_DEPTH,
    parameter logic [CHANNELS-1:0]  ACTIVE_MASK = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic    [CHANNELS-1:0]  up_empty,
    input  packet_t [CHANNELS-1:0]  up_rdata,
    output logic    [CHANNELS-1:0]  up_deq,
    input  logic    [CHANNELS-1:0]  dn_deq,
    output logic    [CHANNELS-1:0]  dn_empty,
    output packet_t [CHANNELS-1:0]  dn_rdata,
    input  logic                    flush,
    output logic                    busy
);

    logic [CHANNELS-1:0] nonempty;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        if (ACTIVE_MASK[g]) begin : g_live
            pe_port_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_empty (up_empty[g]),
                .up_rdata (up_rdata[g]),
                .up_deq   (up_deq[g]),
                .dn_deq   (dn_deq[g]),
                .dn_empty (dn_empty[g]),
                .dn_rdata (dn_rdata[g]),
                .nonempty (nonempty[g])
            );
        end else begin : g_edge
            // Edge channel: never pops upstream, always reads empty
            assign up_deq[g]   = 1'b0;
            assign dn_empty[g] = 1'b1;
            assign dn_rdata[g] = '0;
            assign nonempty[g] = 1'b0;
        end
    end

    assign busy = |nonempty;

endmodule

// File: doc/pe_cluster_port_buf.md
PE_CLUSTER_PORT_BUF -- requirements
Module: pe_cluster_port_buf

Interface
REQ-001 Parameter CHANNELS, default 8, SHALL set the number of independent boundary links; legal range 1..16.
REQ-002 Parameter DEPTH, default 2, SHALL set entries per channel FIFO; power of two, legal range 2..16.
REQ-003 Parameter ACTIVE_MASK, default all ones (CHANNELS bits), SHALL mark live channels; a 0 bit denotes an edge channel that is tied off.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 up_empty  input  1 x CHANNELS  SHALL be the upstream empty flag per channel.
REQ-007 up_rdata  input  packet_t x CHANNELS  SHALL be upstream head data, valid when up_empty[i]=0.
REQ-008 up_deq  output  1 x CHANNELS  SHALL pop upstream entry i at the clock edge where it is high.
REQ-009 dn_deq  input  1 x CHANNELS  SHALL be the downstream pop request per channel.
REQ-010 dn_empty  output  1 x CHANNELS  SHALL be high when channel i holds no entry.
REQ-011 dn_rdata  output  packet_t x CHANNELS  SHALL present channel i head entry.
REQ-012 flush  input  1  SHALL be a synchronous discard of all buffered entries.
REQ-013 busy  output  1  SHALL be high when any active channel holds at least one entry.

Function
REQ-014 Each active channel SHALL hold a count 0..DEPTH, a read pointer and a write pointer, both wrapping modulo DEPTH.
REQ-015 up_deq[i] SHALL equal (up_empty[i]=0) AND (count<DEPTH) AND (flush=0) AND NOT in reset, combinationally.
REQ-016 When up_deq[i]=1, up_rdata[i] SHALL be written at wr_ptr at that edge; wr_ptr advances by 1.
REQ-017 A word captured at edge N SHALL appear on dn_rdata with dn_empty=0 in the cycle after edge N (latency 1).
REQ-018 dn_empty[i] SHALL equal (count=0); dn_rdata[i] SHALL be storage[rd_ptr] read combinationally from registers.
REQ-019 dn_deq[i]=1 with count>0 SHALL advance rd_ptr by 1 at the edge; dn_deq[i] with count=0 SHALL be ignored with no state change.
REQ-020 Push and pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-021 When full, up_deq SHALL stay low even if dn_deq is high that cycle; the freed slot is refilled no earlier than the next cycle.
REQ-022 With DEPTH>=2 and continuous upstream data, no downstream backpressure, each channel SHALL sustain 1 word per cycle.
REQ-023 flush=1 SHALL force up_deq low, ignore dn_deq, and clear count and both pointers at the edge; data storage need not be cleared.
REQ-024 Inactive channels SHALL drive up_deq=0, dn_empty=1, dn_rdata='0 and instantiate no storage.
REQ-025 Channels SHALL be fully independent; no arbitration or ordering between channels.
REQ-026 busy SHALL be the registered-state OR of (count!=0) over active channels, no extra latency beyond count.

Reset
REQ-027 rst low SHALL asynchronously clear every count and pointer to 0; outputs then read dn_empty=all 1, busy=0, up_deq=all 0.
REQ-028 Reset asserted mid-transfer SHALL discard buffered entries; no partial word survives deassertion.
REQ-029 Storage array SHALL not require reset; dn_rdata after reset is don't-care until dn_empty falls, except inactive channels ('0).

Structure
REQ-030 packet_t SHALL come from pe_types; no new types; a PORT_BUF_DEPTH default constant SHALL be added to pe_types.
REQ-031 One sub-module, pe_port_fifo (single channel, DEPTH-parameterised), SHALL be instantiated per active channel via generate.
REQ-032 The block SHALL bolt onto pe_cluster boundary ingress/egress arrays without changing their deq/empty/rdata semantics.

Verification
REQ-033 Reset then up_empty[0]=0, up_rdata[0]=0xA5 one cycle, dn_deq=0 -> up_deq[0]=1 that cycle, next cycle dn_empty[0]=0, dn_rdata[0]=0xA5, busy=1.
REQ-034 DEPTH=2, ch3 feeds 0x1,0x2,0x3 back-to-back, dn_deq=0 -> up_deq high 2 cycles then low; after dn_deq pulse reads 0x1, next up_deq pops 0x3 following cycle.
REQ-035 Full ch1 with simultaneous push/pop in steady stream 0x10..0x1F, dn_deq=1 constantly from non-full state -> 16 words out in order, count constant, 1 word/cycle.
REQ-036 ch5 holds 2 entries, flush=1 one cycle with up_empty=0 -> up_deq[5]=0 that cycle, next cycle dn_empty[5]=1, busy=0.
REQ-037 ACTIVE_MASK=8'b0111_1110, drive all channels -> up_deq[0]=up_deq[7]=0, dn_empty[0]=dn_empty[7]=1, dn_rdata='0 for both.
REQ-038 rst pulsed low mid-clock while ch2 holds 0x7 -> dn_empty[2]=1 immediately, busy=0 without waiting for clk edge.
